// File: rtl/nms_stream.sv
// Canny non-maximum suppression with internal line buffers and a 3x3 window. Output latency: 2 cycles after the completing input.
// There is no backpressure: input arrives on gradient_data_valid, and gaps stall the window without changing the output sequence.
module nms_stream #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int MAG_W = 11
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [MAG_W-1:0]         gradient_magnitude,
  input  logic [1:0]               gradient_direction,
  input  logic                     gradient_data_valid,
  input  logic [MAG_W-1:0]         low_thresh,
  input  logic [MAG_W-1:0]         high_thresh,
  output logic [MAG_W-1:0]         nms_magnitude,
  output logic [1:0]               nms_direction,
  output logic [1:0]               nms_edge_class,
  output logic [$clog2(IMG_W)-1:0] nms_x,
  output logic [$clog2(IMG_H)-1:0] nms_y,
  output logic                     nms_valid,
  output logic                     nms_frame_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [1:0]       dir;
  } pix_t;

  pix_t lb1 [IMG_W];
  pix_t lb2 [IMG_W];
  pix_t win [3][3];
  pix_t cur, rd1, rd2;

  logic [XW-1:0] col;
  logic [YW-1:0] row;

  logic             v0, fd0;
  logic [XW-1:0]    x0;
  logic [YW-1:0]    y0;
  logic             v1, fd1;
  logic [XW-1:0]    x1;
  logic [YW-1:0]    y1;
  logic [MAG_W-1:0] cen1, prv1, nxt1;
  logic [1:0]       dir1;
  logic [MAG_W-1:0] pm, nm;
  logic             keep;
  logic [1:0]       cls;

  assign cur = {gradient_magnitude, gradient_direction};
  assign rd1 = lb1[col];
  assign rd2 = lb2[col];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col <= '0;
      row <= '0;
    end else if (gradient_data_valid) begin
      if (col == XW'(IMG_W-1)) begin
        col <= '0;
        row <= (row == YW'(IMG_H-1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window columns: 0 = oldest (col-2), 2 = newest; rows: 0 = row-2, 2 = current row.
  always_ff @(posedge clk) begin
    if (gradient_data_valid) begin
      lb1[col] <= cur;
      lb2[col] <= rd1;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= rd2;
      win[1][2] <= rd1;
      win[2][2] <= cur;
    end
  end

  always_comb begin
    pm = '0;
    nm = '0;
    case (win[1][1].dir)
      2'd0: begin pm = win[1][0].mag; nm = win[1][2].mag; end
      2'd1: begin pm = win[0][2].mag; nm = win[2][0].mag; end
      2'd2: begin pm = win[0][1].mag; nm = win[2][1].mag; end
      default: begin pm = win[0][0].mag; nm = win[2][2].mag; end
    endcase
  end

  always_comb begin
    keep = (cen1 > prv1) && (cen1 >= nxt1);
    cls  = 2'd0;
    if (keep) begin
      if (cen1 >= high_thresh)     cls = 2'd2;
      else if (cen1 >= low_thresh) cls = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      v0   <= 1'b0;
      fd0  <= 1'b0;
      x0   <= '0;
      y0   <= '0;
      v1   <= 1'b0;
      fd1  <= 1'b0;
      x1   <= '0;
      y1   <= '0;
      cen1 <= '0;
      prv1 <= '0;
      nxt1 <= '0;
      dir1 <= '0;
    end else begin
      v0   <= gradient_data_valid && (row >= YW'(2)) && (col >= XW'(2));
      fd0  <= (col == XW'(IMG_W-1)) && (row == YW'(IMG_H-1));
      x0   <= col - 1'b1;
      y0   <= row - 1'b1;
      v1   <= v0;
      fd1  <= fd0;
      x1   <= x0;
      y1   <= y0;
      cen1 <= win[1][1].mag;
      dir1 <= win[1][1].dir;
      prv1 <= pm;
      nxt1 <= nm;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      nms_magnitude  <= '0;
      nms_direction  <= '0;
      nms_edge_class <= '0;
      nms_x          <= '0;
      nms_y          <= '0;
      nms_valid      <= 1'b0;
      nms_frame_done <= 1'b0;
    end else begin
      nms_valid      <= v1;
      nms_frame_done <= v1 && fd1;
      if (v1) begin
        nms_magnitude  <= keep ? cen1 : '0;
        nms_direction  <= dir1;
        nms_edge_class <= cls;
        nms_x          <= x1;
        nms_y          <= y1;
      end
    end
  end
endmodule
